// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity types, legal bit periods.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] PRESCALE_8       = 6'd8;
  localparam logic [5:0] PRESCALE_16      = 6'd16;
  localparam logic [5:0] PRESCALE_32      = 6'd32;
  localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_16;

  // Map any unsupported bit period onto the default; never flagged.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: legal_prescale = p;
      default:                              legal_prescale = PRESCALE_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the transmitter: cycle counter plus data-bit index.
module uart_tx_bit_timer
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       clear,
  input  logic       enable,
  input  logic       idx_en,
  input  logic [5:0] prescale,
  output logic       bit_done,
  output logic [2:0] bit_idx
);

  logic [5:0] cycle_cnt;

  // Last cycle of the current bit period.
  always_comb begin
    bit_done = enable && (cycle_cnt == 6'(prescale - 6'd1));
  end

  // Cycle counter wraps at every bit boundary; data index steps only in the data phase.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      cycle_cnt <= '0;
      bit_idx   <= '0;
    end else if (enable) begin
      cycle_cnt <= bit_done ? '0 : 6'(cycle_cnt + 6'd1);
      if (idx_en && bit_done) begin
        bit_idx <= 3'(bit_idx + 3'd1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  tx_state_t             state, state_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  parity_q;
  logic [5:0]            prescale_q;
  logic                  accept;
  logic                  bit_done;
  logic [2:0]            bit_idx;
  logic [2:0]            tx_idx;
  logic                  tx_next;
  logic                  busy_next;

  uart_tx_bit_timer u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (accept),
    .enable   (state != IDLE),
    .idx_en   (state == DATA),
    .prescale (prescale_q),
    .bit_done (bit_done),
    .bit_idx  (bit_idx)
  );

  // Next-state logic; a request on the final stop-bit cycle is taken so frames abut.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (Data_Valid) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        if (bit_done && (bit_idx == 3'(DATA_WIDTH - 1))) begin
          state_next = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) state_next = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (Data_Valid) begin
            accept     = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level for the coming cycle, chosen from the next state so the output flop
  // changes exactly at bit boundaries.
  always_comb begin
    tx_idx    = ((state == DATA) && bit_done) ? 3'(bit_idx + 3'd1) : bit_idx;
    busy_next = (state_next != IDLE);
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_q[tx_idx];
      PARITY:  tx_next = parity_q;
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

  // State, output flops and frame holding registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      TX_OUT     <= 1'b1;
      busy       <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      parity_q   <= 1'b0;
      prescale_q <= '0;
    end else begin
      state  <= state_next;
      TX_OUT <= tx_next;
      busy   <= busy_next;
      if (accept) begin
        data_q     <= P_DATA;
        par_en_q   <= PAR_EN;
        parity_q   <= (^P_DATA) ^ PAR_TYP;
        prescale_q <= legal_prescale(Prescale);
      end
    end
  end

endmodule
